// File: rtl/vram_line_fetch.sv
// vram_line_fetch: streams one display line per lineStart pulse from VRAM into a
// double-buffered line store. Each line is LINE_BYTES bytes read from
// consecutive addresses starting at lineAddr. The pixel generator reads the
// other bank of the store at the same time.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   lineStart       one-cycle pulse: swap banks and start fetching a new line
//   lineAddr        VRAM base address of the line, sampled with lineStart
//   readoutAddr     registered VRAM display-side read address
//   readoutData     VRAM display-side read data
//   pixRdAddr       byte index into the display bank
//   pixRdData       registered display-bank byte (00 when the index is past the line)
//   busy            fetch in progress (ARM or FETCH)
//   done            one-cycle pulse on the final capture edge
//   overrun         sticky: lineStart arrived before the fetch completed
//   overrunClr      clears overrun (a coincident new overrun takes priority)
module vram_line_fetch #(
  parameter int unsigned LINE_BYTES = 80,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lineStart,
  input  logic [ADDR_W-1:0] lineAddr,
  output logic [ADDR_W-1:0] readoutAddr,
  input  logic [7:0]        readoutData,
  input  logic [6:0]        pixRdAddr,
  output logic [7:0]        pixRdData,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              overrunClr
);

  localparam int unsigned IDX_W     = 7;
  localparam int unsigned BUF_DEPTH = 256;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(LINE_BYTES - 1);
  localparam logic [7:0]       LINE_BYTES_W = 8'(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FETCH = 2'd2
  } fetchStateT;

  fetchStateT state;
  fetchStateT stateNext;

  logic             phase;
  logic             fillBank;
  logic [IDX_W-1:0] idx;
  logic             captureEdge;
  logic             finalEdge;
  logic             abortFetch;

  // Two banks of 128 bytes each, addressed {bank, byteIndex}; never reset.
  logic [7:0] lineBuf [BUF_DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and edge qualification.
  always_comb begin
    stateNext   = state;
    captureEdge = 1'b0;
    finalEdge   = 1'b0;
    abortFetch  = 1'b0;

    // phase==1 edges carry the data the VRAM sampled on the preceding phase==0 edge.
    captureEdge = (state == FETCH) && phase;
    finalEdge   = captureEdge && (idx == LAST_IDX);
    abortFetch  = lineStart && (state != IDLE) && !finalEdge;

    case (state)
      IDLE:    if (lineStart) stateNext = ARM;
      // The VRAM latches readoutAddr on this phase==0 edge.
      ARM:     if (!phase) stateNext = FETCH;
      FETCH:   if (finalEdge) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // A new line always restarts in ARM, after any final capture completes.
    if (lineStart) stateNext = ARM;
  end

  // Phase tracker, fetch pointers, status flags and pixel readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= 1'b0;
      fillBank    <= 1'b0;
      idx         <= '0;
      readoutAddr <= '0;
      pixRdData   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      phase <= ~phase;

      if (captureEdge) begin
        idx         <= idx + IDX_W'(1);
        readoutAddr <= readoutAddr + ADDR_W'(1);
      end

      if (lineStart) begin
        idx         <= '0;
        readoutAddr <= lineAddr;
        fillBank    <= ~fillBank;
      end

      busy <= (stateNext != IDLE);
      done <= finalEdge;

      if (abortFetch) begin
        overrun <= 1'b1;
      end else if (overrunClr) begin
        overrun <= 1'b0;
      end

      // Uses the pre-swap display bank on a lineStart edge.
      if ({1'b0, pixRdAddr} < LINE_BYTES_W) begin
        pixRdData <= lineBuf[{~fillBank, pixRdAddr}];
      end else begin
        pixRdData <= 8'h00;
      end
    end
  end

  // Line store write port; the coincident-lineStart capture lands in the old fill bank.
  always_ff @(posedge clk) begin
    if (!rst && captureEdge) begin
      lineBuf[{fillBank, idx}] <= readoutData;
    end
  end

endmodule

// File: doc/vram_line_fetch.md
# vram_line_fetch

Display-side consumer of the VRAM readout port. On each line-start pulse it streams LINE_BYTES consecutive bytes from VRAM, starting at a supplied base address, into a double-buffered line buffer. Meanwhile the pixel generator reads the previously fetched line from the other bank. It sits between the VRAM readout port and the pixel/attribute generator, and tracks the VRAM's alternating display/host read slots.

## Interface
Parameters:
- LINE_BYTES, 80, bytes fetched per line (2..128)
- ADDR_W, 13, VRAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset; VRAM nrst is driven from ~rst, so both leave reset on the same edge
- lineStart  in  1  one-cycle pulse: swap banks, begin fetching a new line
- lineAddr  in  ADDR_W  VRAM base address of the line; sampled on the lineStart edge
- readoutAddr  out  ADDR_W  registered VRAM display-side read address
- readoutData  in  8  VRAM display-side read data
- pixRdAddr  in  7  pixel-side byte index into the display bank
- pixRdData  out  8  registered display-bank byte
- busy  out  1  fetch in progress (ARM or FETCH state)
- done  out  1  one-cycle pulse on the final capture edge
- overrun  out  1  sticky: lineStart arrived while a fetch was incomplete
- overrunClr  in  1  clears overrun

## Operation
- Internal phase bit mirrors the VRAM slot toggle: reset to 0, inverts every clk.
  - The VRAM samples readoutAddr on edges where phase==0.
  - Its output is valid for capture on the following phase==1 edge.
- States:
  - IDLE -> ARM on lineStart. Loads readoutAddr=lineAddr and idx=0, toggles fillBank.
  - ARM -> FETCH on the next phase==0 edge, where the VRAM samples the address.
  - FETCH, phase==1 edge: buf[fillBank][idx] <= readoutData; idx++; readoutAddr++.
    - If idx was LINE_BYTES-1: pulse done, go to IDLE.
  - FETCH, phase==0 edge: no fetcher action; the VRAM samples the new address.
- Address arithmetic is modulo 2^ADDR_W: base 8190 fetches 8190, 8191, 0, 1, …
- Display bank is always ~fillBank. The banks are independent, so fill writes and pixel reads never collide.
- pixRdData <= buf[~fillBank][pixRdAddr]. pixRdAddr >= LINE_BYTES returns 8'h00.
- lineStart while busy and not on the final capture edge:
  - Abort the fetch and set overrun.
  - Swap banks anyway; the partial bank becomes the display bank.
  - Restart in ARM with the new lineAddr.
- lineStart coincident with the final capture edge:
  - The capture completes into the old fill bank and done pulses.
  - Then the swap and restart proceed, and overrun is not set.
- overrunClr and an overrun-setting event on the same edge: set wins.
- readoutAddr holds its last value in IDLE.
- Reset mid-fetch: immediate return to IDLE. Line buffer contents are not cleared.
- Reset values: readoutAddr=0, pixRdData=0, busy=0, done=0, overrun=0, phase=0, fillBank=0, idx=0, state=IDLE.

## Timing
- lineStart to first VRAM sample: 1 cycle if the lineStart edge has phase==1, 2 cycles if it has phase==0.
- Throughput: one byte per 2 cycles.
- lineStart to done: 2·LINE_BYTES cycles (lineStart on a phase==1 edge) or 2·LINE_BYTES+1 cycles (phase==0 edge).
  - Default: 160 or 161 cycles, well inside an 800-clock line.
- busy rises on the edge after lineStart and falls on the done edge.
- pixRdData latency: 1 cycle.
- A pixel read sampled on the lineStart edge uses the pre-swap display bank; the swap is visible from the next edge.
- The host slot (phase==1) is never used by this block.

## Test plan
- Preload VRAM[i]=i&FF; lineStart at cycle 3 with lineAddr=0x0100 -> done 160/161 cycles later; after a second lineStart, pixRdAddr 0..79 returns 0x00..0x4F.
- lineAddr=8190, LINE_BYTES=80 -> bytes 0xFE, 0xFF, 0x00, 0x01, … with no out-of-range access.
- Pulse lineStart on a phase==0 edge and, separately, on a phase==1 edge -> byte 0 is correct in both cases (no stale capture); done latency is 161 and 160 respectively.
- lineStart 40 cycles into a fetch -> overrun=1, partial bank is displayed, new fetch completes; overrunClr -> overrun=0; overrunClr coincident with a new overrun -> overrun stays 1.
- lineStart on the done edge -> done=1, overrun=0, new fetch begins; the completed line is fully readable.
- rst asserted mid-fetch -> next cycle busy=0, readoutAddr=0, pixRdData=0; a subsequent fetch succeeds with phase realigned to the VRAM toggle.
